// File: rtl/outerprod_accum_tm.sv
// Time-multiplexed RBM outer-product accumulator: accumulates v_i*h_j into a positive or
// negative bank LANES columns per cycle, then streams (pos - neg) >>> lr_shift as delta beats.
module outerprod_accum_tm #(
    parameter int unsigned I_TILE = 64,
    parameter int unsigned H_TILE = 64,
    parameter int unsigned LANES  = 8,
    parameter int unsigned V_W    = 8,
    parameter int unsigned H_W    = 16,
    parameter int unsigned ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_neg,
    input  logic                     s_last,
    input  logic [I_TILE*V_W-1:0]    s_v,
    input  logic [H_TILE*H_W-1:0]    s_h,
    input  logic                     clr_pos,
    input  logic                     clr_neg,
    input  logic                     rd_start,
    input  logic [4:0]               lr_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ACC_W-1:0]   out_data,
    output logic                     out_last,
    output logic                     done,
    output logic                     busy,
    output logic                     sat_flag
);

    localparam int unsigned N      = I_TILE * H_TILE;
    localparam int unsigned BEATS  = N / LANES;
    localparam int unsigned GROUPS = H_TILE / LANES;
    localparam int unsigned AW     = $clog2(N);
    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned ROW_W  = (I_TILE > 1) ? $clog2(I_TILE) : 1;
    localparam int unsigned GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned PW     = V_W + H_W + 1;
    localparam int unsigned SW     = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam int unsigned DW     = ACC_W + 1;

    // Clamp limits expressed at the width of the unclamped sum / difference.
    localparam logic signed [SW-1:0] S_MAX = SW'({1'b0, {(ACC_W-1){1'b1}}});
    localparam logic signed [SW-1:0] S_MIN = ~S_MAX;
    localparam logic signed [DW-1:0] D_MAX = DW'({1'b0, {(ACC_W-1){1'b1}}});
    localparam logic signed [DW-1:0] D_MIN = ~D_MAX;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_READ  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [ROW_W-1:0]          r_row;
    logic [GRP_W-1:0]          r_grp;
    logic [I_TILE*V_W-1:0]     r_v;
    logic [H_TILE*H_W-1:0]     r_h;
    logic                      r_neg;
    logic                      r_last;
    logic                      r_clr_pos;
    logic                      r_clr_neg;
    logic [4:0]                r_shift;
    logic                      r_s_ready;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_out_valid;
    logic                      r_out_last;
    logic [LANES*ACC_W-1:0]    r_out_data;
    logic                      r_sat;
    logic signed [ACC_W-1:0]   r_bank_pos [N];
    logic signed [ACC_W-1:0]   r_bank_neg [N];

    logic signed [V_W-1:0]     w_vrow;
    logic [CNT_W-1:0]          w_ridx;
    logic                      w_ridx_last;
    logic [AW-1:0]             w_addr  [LANES];
    logic [AW-1:0]             w_raddr [LANES];
    logic signed [PW-1:0]      w_prod  [LANES];
    logic signed [ACC_W-1:0]   w_old   [LANES];
    logic signed [SW-1:0]      w_sum   [LANES];
    logic signed [ACC_W-1:0]   w_new   [LANES];
    logic signed [DW-1:0]      w_diff  [LANES];
    logic signed [ACC_W-1:0]   w_dsat  [LANES];
    logic [LANES-1:0]          w_sat;
    logic [LANES*ACC_W-1:0]    w_beat;

    // Per-lane MAC with saturation, and the delta beat for the next readback slot.
    always_comb begin
        w_vrow      = r_v[r_row*V_W +: V_W];
        w_ridx      = r_out_valid ? r_cnt + CNT_W'(1) : r_cnt;
        w_ridx_last = (w_ridx == CNT_W'(BEATS - 1));
        w_sat       = '0;
        w_beat      = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            w_addr[l]  = AW'(r_cnt * LANES + l);
            w_raddr[l] = AW'(w_ridx * LANES + l);
            w_prod[l]  = PW'(w_vrow) * PW'($signed({1'b0, r_h[(r_grp*LANES + l)*H_W +: H_W]}));
            w_old[l]   = r_neg ? r_bank_neg[w_addr[l]] : r_bank_pos[w_addr[l]];
            w_sum[l]   = SW'(w_old[l]) + SW'(w_prod[l]);
            w_new[l]   = w_sum[l][ACC_W-1:0];
            if (w_sum[l] > S_MAX) begin
                w_new[l] = ACC_W'(S_MAX);
                w_sat[l] = 1'b1;
            end else if (w_sum[l] < S_MIN) begin
                w_new[l] = ACC_W'(S_MIN);
                w_sat[l] = 1'b1;
            end
            w_diff[l] = DW'(r_bank_pos[w_raddr[l]]) - DW'(r_bank_neg[w_raddr[l]]);
            w_dsat[l] = w_diff[l][ACC_W-1:0];
            if (w_diff[l] > D_MAX) begin
                w_dsat[l] = ACC_W'(D_MAX);
            end else if (w_diff[l] < D_MIN) begin
                w_dsat[l] = ACC_W'(D_MIN);
            end
            w_beat[l*ACC_W +: ACC_W] = w_dsat[l] >>> r_shift;
        end
    end

    // Bank storage: cleared or accumulated LANES words per cycle, read-only during READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                r_bank_pos[i] <= '0;
                r_bank_neg[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (r_clr_pos) r_bank_pos[w_addr[l]] <= '0;
                if (r_clr_neg) r_bank_neg[w_addr[l]] <= '0;
            end
        end else if (r_state == ST_ACCUM) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (r_neg) r_bank_neg[w_addr[l]] <= w_new[l];
                else       r_bank_pos[w_addr[l]] <= w_new[l];
            end
        end
    end

    // Control FSM; s_ready/busy are written alongside every state change so they stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_row       <= '0;
            r_grp       <= '0;
            r_v         <= '0;
            r_h         <= '0;
            r_neg       <= 1'b0;
            r_last      <= 1'b0;
            r_clr_pos   <= 1'b0;
            r_clr_neg   <= 1'b0;
            r_shift     <= '0;
            r_s_ready   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_sat       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_row <= '0;
                    r_grp <= '0;
                    if (clr_pos || clr_neg) begin
                        r_state   <= ST_CLEAR;
                        r_clr_pos <= clr_pos;
                        r_clr_neg <= clr_neg;
                        r_sat     <= 1'b0;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b1;
                    end else if (rd_start) begin
                        r_state   <= ST_READ;
                        r_shift   <= lr_shift;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b1;
                    end else if (s_valid && r_s_ready) begin
                        r_state   <= ST_ACCUM;
                        r_v       <= s_v;
                        r_h       <= s_h;
                        r_neg     <= s_neg;
                        r_last    <= s_last;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(BEATS - 1)) begin
                        r_state   <= ST_IDLE;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (|w_sat) r_sat <= 1'b1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_grp == GRP_W'(GROUPS - 1)) begin
                        r_grp <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end else begin
                        r_grp <= r_grp + GRP_W'(1);
                    end
                    if (r_cnt == CNT_W'(BEATS - 1)) begin
                        if (r_last) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_s_ready <= 1'b1;
                            r_busy    <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_beat;
                        r_out_last  <= w_ridx_last;
                    end else if (out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= ST_FIN;
                            r_done      <= 1'b1;
                        end else begin
                            r_cnt      <= w_ridx;
                            r_out_data <= w_beat;
                            r_out_last <= w_ridx_last;
                        end
                    end
                end
                ST_FIN: begin
                    r_state   <= ST_IDLE;
                    r_s_ready <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_s_ready <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready   = r_s_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign done      = r_done;
    assign busy      = r_busy;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_outerprod_accum_tm.sv
// Scoreboard bench for outerprod_accum_tm: a 32-bit and a 24-bit accumulator instance run in
// lockstep on shared stimulus; a longint bank model supplies every expected readback beat.
module tb_outerprod_accum_tm;

    logic        clk = 1'b0;
    logic        rst_n, s_valid, s_neg, s_last, clr_pos, clr_neg, rd_start, out_ready;
    logic [31:0] s_v;
    logic [63:0] s_h;
    logic [4:0]  lr_shift;

    logic        a_s_ready, a_out_valid, a_out_last, a_done, a_busy, a_sat;
    logic [63:0] a_out_data;
    logic        b_s_ready, b_out_valid, b_out_last, b_done, b_busy, b_sat;
    logic [47:0] b_out_data;

    logic        sel;
    logic        o_s_ready, o_out_valid, o_out_last, o_done, o_busy, o_sat;
    logic [63:0] o_out_data;

    longint      m_pos [2][16];
    longint      m_neg [2][16];
    logic [64:0] sb_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    outerprod_accum_tm #(.I_TILE(4), .H_TILE(4), .LANES(2), .V_W(8), .H_W(16), .ACC_W(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(a_s_ready), .s_neg(s_neg),
        .s_last(s_last), .s_v(s_v), .s_h(s_h), .clr_pos(clr_pos), .clr_neg(clr_neg),
        .rd_start(rd_start), .lr_shift(lr_shift), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_last(a_out_last), .done(a_done), .busy(a_busy), .sat_flag(a_sat));

    outerprod_accum_tm #(.I_TILE(4), .H_TILE(4), .LANES(2), .V_W(8), .H_W(16), .ACC_W(24)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(b_s_ready), .s_neg(s_neg),
        .s_last(s_last), .s_v(s_v), .s_h(s_h), .clr_pos(clr_pos), .clr_neg(clr_neg),
        .rd_start(rd_start), .lr_shift(lr_shift), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .done(b_done), .busy(b_busy), .sat_flag(b_sat));

    always_comb begin
        o_s_ready   = sel ? b_s_ready   : a_s_ready;
        o_out_valid = sel ? b_out_valid : a_out_valid;
        o_out_last  = sel ? b_out_last  : a_out_last;
        o_done      = sel ? b_done      : a_done;
        o_busy      = sel ? b_busy      : a_busy;
        o_sat       = sel ? b_sat       : a_sat;
        o_out_data  = sel ? 64'(b_out_data) : a_out_data;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int accw(input int d);
        return (d == 1) ? 24 : 32;
    endfunction

    function automatic longint sat(input longint x, input int w);
        longint mx = (64'sd1 <<< (w - 1)) - 1;
        if (x > mx) return mx;
        if (x < -mx - 1) return -mx - 1;
        return x;
    endfunction

    task automatic model_sample(input logic [31:0] v, input logic [63:0] h, input bit neg);
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 4; r++)
                for (int j = 0; j < 4; j++) begin
                    longint p = longint'($signed(v[r*8 +: 8])) * longint'(h[j*16 +: 16]);
                    if (neg) m_neg[d][r*4+j] = sat(m_neg[d][r*4+j] + p, accw(d));
                    else     m_pos[d][r*4+j] = sat(m_pos[d][r*4+j] + p, accw(d));
                end
    endtask

    task automatic model_zero(input bit p, input bit n);
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 16; a++) begin
                if (p) m_pos[d][a] = 0;
                if (n) m_neg[d][a] = 0;
            end
    endtask

    // Called at the first negedge after the accept edge; waits for the return to IDLE.
    task automatic sample_tail(input logic [31:0] v, input logic [63:0] h, input bit neg, input bit last);
        int low = 0;
        int dones = 0;
        s_valid = 1'b0; s_v = ~v; s_h = ~h; s_neg = ~neg; s_last = 1'b0;
        model_sample(v, h, neg);
        for (int i = 0; i < 40; i++) begin
            if (o_done) begin
                dones++;
                chk("done_position", 64'(i), 64'd8);
                chk("done_vs_out_valid", 64'(o_out_valid), 64'd0);
            end
            if (o_s_ready) break;
            low++;
            @(negedge clk);
        end
        chk("s_ready_low_cycles", 64'(low), 64'(8 + int'(last)));
        chk("done_pulse_count", 64'(dones), 64'(last));
    endtask

    task automatic send_sample(input logic [31:0] v, input logic [63:0] h, input bit neg, input bit last);
        @(negedge clk);
        s_v = v; s_h = h; s_neg = neg; s_last = last; s_valid = 1'b1;
        chk("s_ready_idle", 64'(o_s_ready), 64'd1);
        @(negedge clk);
        sample_tail(v, h, neg, last);
    endtask

    task automatic do_clear(input bit p, input bit n);
        int cnt = 0;
        @(negedge clk);
        clr_pos = p; clr_neg = n;
        @(negedge clk);
        clr_pos = 1'b0; clr_neg = 1'b0;
        s_valid = 1'b1; s_v = 32'h7f7f7f7f; s_h = '1; s_neg = 1'b0; s_last = 1'b1;
        chk("clear_s_ready", 64'(o_s_ready), 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (i == 3) s_valid = 1'b0;
            if (!o_busy) break;
            cnt++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        model_zero(p, n);
        chk("clear_busy_cycles", 64'(cnt), 64'd8);
        chk("clear_sat_flag", 64'(o_sat), 64'd0);
        @(negedge clk);
        chk("clear_no_accept", 64'(o_busy), 64'd0);
    endtask

    task automatic do_read(input logic [4:0] shift, input bit stall);
        int          hs = 0;
        int          step = 0;
        bit          done_seen = 1'b0;
        bit          prev_stall = 1'b0;
        logic [63:0] pd = '0;
        logic        pl = 1'b0;
        int          w = accw(int'(sel));
        longint      mask = (64'sd1 <<< w) - 1;
        for (int k = 0; k < 8; k++) begin
            logic [63:0] e = '0;
            for (int l = 0; l < 2; l++) begin
                longint d = sat(m_pos[int'(sel)][k*2+l] - m_neg[int'(sel)][k*2+l], w) >>> shift;
                e = e | (64'(d & mask) << (l * w));
            end
            sb_q.push_back({(k == 7), e});
        end
        @(negedge clk);
        lr_shift = shift; rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0; lr_shift = 5'h1f;
        for (int c = 0; c < 200; c++) begin
            if (o_done) begin
                done_seen = 1'b1;
                chk("read_done_vs_out_valid", 64'(o_out_valid), 64'd0);
                chk("read_handshakes", 64'(hs), 64'd8);
                break;
            end
            if (prev_stall && o_out_valid) begin
                chk("stall_data_hold", o_out_data, pd);
                chk("stall_last_hold", 64'(o_out_last), 64'(pl));
            end
            out_ready = stall ? ((step % 4 == 0) || (step % 4 == 3)) : 1'b1;
            step++;
            if (o_out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("read_extra_beat", 64'd1, 64'd0);
                end else begin
                    logic [64:0] ex = sb_q.pop_front();
                    chk("beat_data", o_out_data, ex[63:0]);
                    chk("beat_last", 64'(o_out_last), 64'(ex[64]));
                end
                hs++;
            end
            prev_stall = o_out_valid && !out_ready;
            pd = o_out_data;
            pl = o_out_last;
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("read_done_seen", 64'(done_seen), 64'd1);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        @(negedge clk);
        chk("read_back_idle", 64'(o_busy), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v6;
        logic [63:0] h6;
        sel = 1'b0;
        rst_n = 1'b0; s_valid = 1'b0; s_neg = 1'b0; s_last = 1'b0; clr_pos = 1'b0; clr_neg = 1'b0;
        rd_start = 1'b0; out_ready = 1'b1; s_v = '0; s_h = '0; lr_shift = '0;
        model_zero(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 64'(o_s_ready), 64'd1);
        chk("rst_out_valid", 64'(o_out_valid), 64'd0);
        chk("rst_out_last", 64'(o_out_last), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_sat_flag", 64'(o_sat), 64'd0);
        chk("rst_out_data", o_out_data, 64'd0);
        rst_n = 1'b1;

        // Positive sample then plain readback.
        send_sample(32'h40404040, {4{16'h8000}}, 1'b0, 1'b1);
        do_read(5'd0, 1'b0);
        // Negative sample; delta is pos - neg.
        send_sample(32'h80808080, {4{16'hffff}}, 1'b1, 1'b1);
        do_read(5'd0, 1'b0);
        // Shifted readback with downstream back-pressure.
        do_read(5'd4, 1'b1);
        // Clear negative bank only; positive bank must survive.
        do_clear(1'b0, 1'b1);
        do_read(5'd0, 1'b0);

        // Saturation on the 24-bit instance.
        sel = 1'b1;
        do_clear(1'b1, 1'b1);
        send_sample(32'h7f7f7f7f, {4{16'hffff}}, 1'b0, 1'b0);
        chk("sat_after_first", 64'(o_sat), 64'd0);
        send_sample(32'h7f7f7f7f, {4{16'hffff}}, 1'b0, 1'b0);
        chk("sat_after_second", 64'(o_sat), 64'd1);
        do_read(5'd0, 1'b0);
        chk("sat_sticky_after_read", 64'(o_sat), 64'd1);
        do_clear(1'b1, 1'b0);
        sel = 1'b0;

        // Asynchronous reset in the middle of an accumulation.
        @(negedge clk);
        s_v = 32'h11223344; s_h = {4{16'h1234}}; s_neg = 1'b0; s_last = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_accum_busy", 64'(o_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_s_ready", 64'(o_s_ready), 64'd1);
        chk("async_rst_busy", 64'(o_busy), 64'd0);
        chk("async_rst_done", 64'(o_done), 64'd0);
        chk("async_rst_out_valid", 64'(o_out_valid), 64'd0);
        @(negedge clk);
        chk("rst_held_done", 64'(o_done), 64'd0);
        model_zero(1'b1, 1'b1);
        v6 = 32'h0100fffe;
        h6 = 64'h0bbf_07d7_03ef_0007;
        s_v = v6; s_h = h6; s_neg = 1'b1; s_last = 1'b0; s_valid = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("accept_after_release", 64'(o_s_ready), 64'd0);
        sample_tail(v6, h6, 1'b1, 1'b0);
        do_read(5'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
